// File: rtl/ws2812b_in_module.sv
// rtl/ws2812b_in_module.sv - WS2812B line decoder into 24-bit GRB words; WS2812B_FORWARD_EN adds data_out chaining
module ws2812b_in_module #(
   parameter int CYCLES_THRESHOLD = 4,
   parameter int CYCLES_MAX_HIGH  = 16,
   parameter int CYCLES_RET       = 450,
   parameter int CYCLES_CNT_WIDTH = 9
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_in,
   output logic [23:0] word,
   output logic        word_valid,
   output logic [7:0]  word_index,
   output logic        frame_done,
   output logic        error,
`ifdef WS2812B_FORWARD_EN
   output logic        data_out,
`endif
   output logic [3:0]  debug_info
);

   localparam int W = CYCLES_CNT_WIDTH;
   localparam logic [W-1:0] CNT_ONE = W'(1);
   localparam logic [W-1:0] RET     = W'(CYCLES_RET);
   localparam logic [W-1:0] RET_M1  = W'(CYCLES_RET - 1);
   localparam logic [W-1:0] THR     = W'(CYCLES_THRESHOLD);
   localparam logic [W-1:0] MAXH_M1 = W'(CYCLES_MAX_HIGH - 1);

   typedef enum logic [1:0] {
      WAIT_GAP = 2'd0,
      IDLE     = 2'd1,
      HIGH     = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic          s1, s2, s3;
   logic          rise, fall;
   logic [W-1:0]  low_cnt, low_cnt_nxt;
   logic [W-1:0]  high_cnt, high_cnt_nxt;
   logic [4:0]    bit_cnt, bit_cnt_nxt;
   logic [7:0]    word_cnt, word_cnt_nxt;
   logic [23:0]   shift, shift_nxt, shift_in;
   logic [23:0]   word_nxt;
   logic [7:0]    word_index_nxt;
   logic          word_valid_nxt, frame_done_nxt, error_nxt;
   logic          bit_val;

   assign rise       = s2 & ~s3;
   assign fall       = ~s2 & s3;
   assign debug_info = {state, s2, bit_cnt[0]};

   // Two-flop synchronizer plus edge-detect register on the raw line
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= data_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) state <= WAIT_GAP;
      else         state <= state_nxt;
   end

   // Next-state, counters and output pulses; the edge sample itself counts as the first cycle of a run
   always_comb begin
      state_nxt      = state;
      low_cnt_nxt    = low_cnt;
      high_cnt_nxt   = high_cnt;
      bit_cnt_nxt    = bit_cnt;
      word_cnt_nxt   = word_cnt;
      shift_nxt      = shift;
      word_nxt       = word;
      word_index_nxt = word_index;
      word_valid_nxt = 1'b0;
      frame_done_nxt = 1'b0;
      error_nxt      = 1'b0;
      bit_val        = 1'b0;
      shift_in       = shift;
      unique case (state)
         WAIT_GAP: begin
            if (s2) begin
               low_cnt_nxt = '0;
            end else if (low_cnt == RET_M1) begin
               low_cnt_nxt = RET;
               state_nxt   = IDLE;
            end else begin
               low_cnt_nxt = low_cnt + 1'b1;
            end
         end
         IDLE: begin
            if (rise) begin
               high_cnt_nxt = CNT_ONE;
               state_nxt    = HIGH;
            end else if (!s2) begin
               if (low_cnt == RET_M1) begin
                  low_cnt_nxt    = RET;
                  frame_done_nxt = (word_cnt != 8'd0);
                  error_nxt      = (bit_cnt != 5'd0);
                  word_cnt_nxt   = 8'd0;
                  bit_cnt_nxt    = 5'd0;
               end else if (low_cnt != RET) begin
                  low_cnt_nxt = low_cnt + 1'b1;
               end
            end
         end
         HIGH: begin
            if (fall) begin
               bit_val     = (high_cnt >= THR);
               shift_in    = {shift[22:0], bit_val};
               shift_nxt   = shift_in;
               low_cnt_nxt = CNT_ONE;
               state_nxt   = IDLE;
               if (bit_cnt == 5'd23) begin
                  word_nxt       = shift_in;
                  word_valid_nxt = 1'b1;
                  word_index_nxt = word_cnt;
                  bit_cnt_nxt    = 5'd0;
                  if (word_cnt != 8'hFF) word_cnt_nxt = word_cnt + 8'd1;
               end else begin
                  bit_cnt_nxt = bit_cnt + 5'd1;
               end
            end else if (high_cnt == MAXH_M1) begin
               error_nxt    = 1'b1;
               bit_cnt_nxt  = 5'd0;
               word_cnt_nxt = 8'd0;
               low_cnt_nxt  = '0;
               state_nxt    = WAIT_GAP;
            end else begin
               high_cnt_nxt = high_cnt + 1'b1;
            end
         end
         default: state_nxt = WAIT_GAP;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         low_cnt    <= '0;
         high_cnt   <= '0;
         bit_cnt    <= 5'd0;
         word_cnt   <= 8'd0;
         shift      <= 24'd0;
         word       <= 24'd0;
         word_index <= 8'd0;
         word_valid <= 1'b0;
         frame_done <= 1'b0;
         error      <= 1'b0;
      end else begin
         low_cnt    <= low_cnt_nxt;
         high_cnt   <= high_cnt_nxt;
         bit_cnt    <= bit_cnt_nxt;
         word_cnt   <= word_cnt_nxt;
         shift      <= shift_nxt;
         word       <= word_nxt;
         word_index <= word_index_nxt;
         word_valid <= word_valid_nxt;
         frame_done <= frame_done_nxt;
         error      <= error_nxt;
      end
   end

`ifdef WS2812B_FORWARD_EN
   // Forward the synchronized line once word 0 of the frame is done; a nonzero in-frame count marks exactly that window
   always_ff @(posedge clk) begin
      if (!resetn) data_out <= 1'b0;
      else         data_out <= s2 & (word_cnt != 8'd0);
   end
`endif

endmodule

// File: tb/tb_ws2812b_in_module.sv
// tb/tb_ws2812b_in_module.sv - randomized run-length model bench for ws2812b_in_module
module tb_ws2812b_in_module;
   localparam int THR  = 4;
   localparam int MAXH = 16;
   localparam int RET  = 450;
   localparam int NMAX = 32000;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        data_in = 1'b0;
   logic [23:0] word;
   logic        word_valid;
   logic [7:0]  word_index;
   logic        frame_done;
   logic        error;
   logic [3:0]  debug_info;
`ifdef WS2812B_FORWARD_EN
   logic        data_out;
`endif

   ws2812b_in_module dut (
      .clk        (clk),
      .resetn     (resetn),
      .data_in    (data_in),
      .word       (word),
      .word_valid (word_valid),
      .word_index (word_index),
      .frame_done (frame_done),
      .error      (error),
`ifdef WS2812B_FORWARD_EN
      .data_out   (data_out),
`endif
      .debug_info (debug_info)
   );

   always #5 clk = ~clk;

   // line[n] is sampled at posedge n; exp_*[m] is what the outputs must show after posedge m
   bit          line [NMAX];
   bit          rst [NMAX];
   bit          exp_wv [NMAX];
   logic [23:0] exp_word [NMAX];
   logic [7:0]  exp_idx [NMAX];
   bit          exp_fd [NMAX];
   bit          exp_err [NMAX];
   bit          exp_dout [NMAX];

   int          n_idx = 0;
   int          played = 0;
   bit          synced = 1'b0;
   int          low_run = 0;
   bit          gap_done = 1'b0;
   int          pend_h = 0;
   int          bits = 0;
   logic [23:0] sh = 24'd0;
   int          wcnt = 0;
   bit          fwd = 1'b0;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_wv = 0;
   int          n_fd = 0;
   int          n_err = 0;
   int          first_wv = -1;
   logic [23:0] hold_word = 24'd0;
   logic [23:0] obs_word [64];
   int          obs_idx [64];

   task automatic chk(string name, int m, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, m, act, exp);
      end
   endtask

   task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // A high run of h samples; a synced pulse reaching MAXH errors at its MAXH-th sample
   task automatic high(int h);
      int h0, lim;
      h0 = n_idx;
      for (int i = 0; i < h; i++) line[h0 + i] = 1'b1;
      if (fwd) begin
         lim = (synced && h >= MAXH) ? MAXH : h;
         for (int i = 0; i < lim; i++) exp_dout[h0 + i + 2] = 1'b1;
      end
      if (synced) begin
         if (h >= MAXH) begin
            exp_err[h0 + MAXH - 1 + 2] = 1'b1;
            synced = 1'b0;
            bits = 0;
            wcnt = 0;
            fwd = 1'b0;
            pend_h = 0;
         end else begin
            pend_h = h;
         end
      end
      low_run = 0;
      gap_done = 1'b0;
      n_idx += h;
   endtask

   // A low run of l samples: decodes the preceding pulse on its first sample, gap on the RET-th low sample
   task automatic low(int l);
      int n0, s;
      bit b;
      n0 = n_idx;
      if (synced && pend_h > 0) begin
         b = (pend_h >= THR);
         sh = {sh[22:0], b};
         bits++;
         if (bits == 24) begin
            exp_wv[n0 + 2] = 1'b1;
            exp_word[n0 + 2] = sh;
            exp_idx[n0 + 2] = 8'(wcnt);
            if (wcnt == 0) fwd = 1'b1;
            wcnt = (wcnt < 255) ? wcnt + 1 : 255;
            bits = 0;
         end
         pend_h = 0;
      end
      if (!gap_done && low_run + l >= RET) begin
         s = n0 + (RET - low_run) - 1;
         if (synced) begin
            if (wcnt > 0) exp_fd[s + 2] = 1'b1;
            if (bits > 0) exp_err[s + 2] = 1'b1;
            wcnt = 0;
            bits = 0;
            fwd = 1'b0;
         end else begin
            synced = 1'b1;
         end
         gap_done = 1'b1;
      end
      for (int i = 0; i < l; i++) line[n0 + i] = 1'b0;
      low_run += l;
      n_idx += l;
   endtask

   task automatic do_reset(int len);
      for (int i = 0; i < len + 2; i++) begin
         exp_wv[n_idx + i] = 1'b0;
         exp_fd[n_idx + i] = 1'b0;
         exp_err[n_idx + i] = 1'b0;
         exp_dout[n_idx + i] = 1'b0;
      end
      for (int i = 0; i < len; i++) begin
         line[n_idx] = 1'b0;
         rst[n_idx] = 1'b1;
         n_idx++;
      end
      synced = 1'b0;
      low_run = 0;
      gap_done = 1'b0;
      pend_h = 0;
      bits = 0;
      wcnt = 0;
      fwd = 1'b0;
      sh = 24'd0;
   endtask

   task automatic send_bit(bit b, bit fixed);
      if (fixed) begin
         high(b ? 5 : 3);
         low(b ? 4 : 6);
      end else begin
         high(b ? int'($urandom_range(15, 4)) : int'($urandom_range(3, 1)));
         low(int'($urandom_range(12, 1)));
      end
   endtask

   task automatic send_word(logic [23:0] w, bit fixed);
      for (int i = 23; i >= 0; i--) send_bit(w[i], fixed);
   endtask

   task automatic send_bits(int n);
      for (int i = 0; i < n; i++) send_bit(1'($urandom), 1'b0);
   endtask

   task automatic check(int m);
      logic exp_s2;
      if (rst[m]) hold_word = 24'd0;
      else if (exp_wv[m]) hold_word = exp_word[m];
      chk("word_valid", m, word_valid, exp_wv[m]);
      if (exp_wv[m]) chk("word_index", m, word_index, exp_idx[m]);
      chk("word", m, word, hold_word);
      chk("frame_done", m, frame_done, exp_fd[m]);
      chk("error", m, error, exp_err[m]);
`ifdef WS2812B_FORWARD_EN
      chk("data_out", m, data_out, exp_dout[m]);
`endif
      exp_s2 = (m == 0 || rst[m] || rst[m - 1]) ? 1'b0 : line[m - 1];
      chk("sync_data", m, debug_info[1], exp_s2);
      if (rst[m]) chk("debug_reset", m, debug_info, 4'd0);
      if (word_valid === 1'b1) begin
         if (n_wv == 0) first_wv = m;
         if (n_wv < 64) begin
            obs_word[n_wv] = word;
            obs_idx[n_wv] = word_index;
         end
         n_wv++;
      end
      if (frame_done === 1'b1) n_fd++;
      if (error === 1'b1) n_err++;
   endtask

   task automatic play();
      while (played < n_idx) begin
         data_in = line[played];
         resetn = !rst[played];
         @(negedge clk);
         check(played);
         played++;
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) obs_idx[i] = -1;

      // Fixed-timing 0xA5C3F0 after the initial gap, then a closing gap
      do_reset(4);
      low(460);
      send_word(24'hA5C3F0, 1'b1);
      low(460);
      play();
      lit("first_latency", first_wv, 676);
      lit("p1_word", obs_word[0], 24'hA5C3F0);
      lit("p1_index", obs_idx[0], 0);
      lit("p1_wv_count", n_wv, 1);
      lit("p1_fd_count", n_fd, 1);
      lit("p1_err_count", n_err, 0);

      // 36 random words in one frame, gap, then a second idle gap
      for (int i = 0; i < 36; i++) send_word(24'($urandom), 1'b0);
      low(460);
      low(460);
      play();
      lit("p2_wv_count", n_wv, 37);
      lit("p2_last_index", obs_idx[36], 35);
      lit("p2_fd_count", n_fd, 2);
      lit("p2_err_count", n_err, 0);

      // Partial word at gap, then a fresh word
      send_bits(10);
      low(460);
      send_word(24'($urandom), 1'b0);
      low(460);
      play();
      lit("p3_err_count", n_err, 1);
      lit("p3_fd_count", n_fd, 3);
      lit("p3_wv_count", n_wv, 38);
      lit("p3_index", obs_idx[37], 0);

      // Over-long pulse, ignored bits until the next gap, then a word
      high(16);
      low(5);
      send_bits(30);
      low(460);
      send_word(24'($urandom), 1'b0);
      low(460);
      play();
      lit("p4_err_count", n_err, 2);
      lit("p4_wv_count", n_wv, 39);
      lit("p4_index", obs_idx[38], 0);
      lit("p4_fd_count", n_fd, 4);

      // Boundary pulses 3/4/15 cycles, a 449-cycle low inside the frame
      for (int i = 0; i < 8; i++) begin
         high(3);  low(6);
         high(4);  low(6);
         high(15); low(6);
      end
      low(443);
      send_word(24'($urandom), 1'b0);
      low(460);
      play();
      lit("p5_word", obs_word[39], 24'h6DB6DB);
      lit("p5_index0", obs_idx[39], 0);
      lit("p5_index1", obs_idx[40], 1);
      lit("p5_wv_count", n_wv, 41);
      lit("p5_fd_count", n_fd, 5);
      lit("p5_err_count", n_err, 2);

      // Reset mid-word, then a full gap and a word
      send_bits(12);
      do_reset(3);
      low(460);
      send_word(24'($urandom), 1'b0);
      low(460);
      play();
      lit("p6_wv_count", n_wv, 42);
      lit("p6_index", obs_idx[41], 0);
      lit("p6_err_count", n_err, 2);
      lit("p6_fd_count", n_fd, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
